gfx_dma: RTL and testbench
==========================

# gfx_dma

Rectangular blit engine for the graphics module: copies a W×H block of bytes from the CPU-side character/sprite RAM (cram) into the 64 KiB video RAM (vram). The CPU programs eight byte registers through its normal RAM write cycle and a write to the start register launches the copy. While the copy runs the block owns the cram bus, and external bus buffers are disabled via `o_active`. Writes into vram are throttled by the video-bus-free signal.

## Interface
- `DstStride`, 256: vram address increment between destination rows (bytes).
- `i_clk` in 1: single system clock (pixel clock, 25.175 MHz nominal).
- `i_rst_b` in 1: asynchronous, active-low reset.
- `i_src_ce_b` in 1: register-window chip enable, active low.
- `i_src_ce2_b` in 1: second register enable, active low (cram address bit 3).
- `o_src_re_b` out 1: cram output enable, active low; tri-stated when idle.
- `io_src_we_b` inout 1: CPU write strobe input when idle; driven high by the block while active.
- `io_src_addr` inout 13: CPU address input when idle; cram read address driven by the block while active.
- `i_src_data` in 8: CPU write data or cram read data.
- `o_dst_we_b` out 1: vram write enable, active low; always driven, high when not writing.
- `o_dst_addr` out 16: vram address, bit 15 selecting the upper 32 KiB chip; tri-stated unless `o_addr_sel`.
- `o_dst_data` out 8: vram write data; tri-stated unless `o_addr_sel`.
- `i_free_vbus_b` in 1: low = video bus free for DMA writes; high = the video scan owns vram.
- `o_active` out 1: high from start until the copy completes. Doubles as the active-low OE of the external CPU bus buffers.
- `o_addr_sel` out 1: high while the block drives the vram address and data bus.

## Operation
- Registers are selected by `i_src_ce_b`=0, `i_src_ce2_b`=0 and `io_src_addr[2:0]`:
  - 0: SRC_L
  - 1: SRC_H
  - 2: DST_L
  - 3: DST_H
  - 4: WIDTH
  - 5: HEIGHT
  - 6: MASK
  - 7: START (data ignored)
- Register writes:
  - While `io_src_we_b`=0 with the window selected and `o_active`=0, the address and data are latched every clock.
  - The latched write commits on the first clock where `io_src_we_b` is sampled high after being low.
  - Writes while active are ignored.
- A committed write to START loads the working counters and sets `o_active`:
  - src pointer = {SRC_H, SRC_L}[12:0]
  - row base = {DST_H, DST_L}
  - column = 0
  - row = 0
- States: IDLE → READ → WRITE → NEXT → READ… → IDLE.
  - READ: drive `io_src_addr` = src pointer, `o_src_re_b`=0. Capture `i_src_data` at the end of the cycle. Go to WRITE only when `i_free_vbus_b`=0; otherwise hold in READ, re-reading the same address.
  - WRITE: `o_dst_addr` = row base + column, `o_dst_data` = captured byte AND MASK, `o_dst_we_b`=0 for exactly one cycle.
  - NEXT: `o_dst_we_b`=1, address and data held.
    - src pointer +1 (wraps at 13 bits), column +1.
    - When column reaches WIDTH: column = 0, row +1, row base += DstStride (wraps at 16 bits).
    - When row reaches HEIGHT: go to IDLE; otherwise go to READ.
- Source data is linear; the destination is strided.
- WIDTH=0 or HEIGHT=0: no vram write occurs, and `o_active` is high for exactly one cycle.
- `o_addr_sel` is high in READ, WRITE and NEXT. `io_src_addr`, `o_src_re_b` and `io_src_we_b` are driven in every non-IDLE state.
- Register contents are not modified by a copy, so START may be re-issued to repeat it.

## Timing
- Reset values:
  - FSM IDLE, all registers 0.
  - `o_active`=0, `o_addr_sel`=0, `o_dst_we_b`=1.
  - `o_src_re_b`, `io_src_we_b`, `io_src_addr`, `o_dst_addr`, `o_dst_data` high-Z.
- Start latency: `o_active` rises on the clock after the START commit edge, entering READ.
- Throughput: 3 cycles per byte with the bus free. A W×H copy lasts 3·W·H cycles of `o_active`.
- Stall:
  - `i_free_vbus_b` is sampled only in READ.
  - A WRITE already entered always completes.
  - Each stalled cycle adds exactly one cycle.
- Completion: on the clock after the final NEXT, `o_active`=0 and `o_addr_sel`=0, and all shared buses are released in that same cycle.
- Reset mid-copy immediately returns to IDLE with the reset values above. A partial copy is acceptable.

## Structure
- Shared package `gfx_dma_pkg`: register offset constants (0–7) and the FSM state enum (IDLE, READ, WRITE, NEXT).
- Sub-module `gfx_dma_regs`: register file plus write-strobe commit detector, producing the register values and a one-cycle `start` pulse.
- The top level holds the FSM, the counters and the tri-state control.

## Test plan
- Program SRC=0x0000, DST=0x1010, W=5, H=5, MASK=0xFF, START with cram preloaded. Required:
  - vram rows 0x1010–0x1014, 0x1110–0x1114 … 0x1410–0x1414 receive cram bytes 0–24 in order.
  - `o_active` is high for 75 cycles.
- MASK=0x0F with source byte 0xA5 → vram byte 0x05.
- Hold `i_free_vbus_b` high for 2 cycles mid-copy → no `o_dst_we_b` pulse during the stall, copy lasts 77 cycles, data correct.
- WIDTH=0 → `o_active` high for 1 cycle, no vram writes.
- Register writes while `o_active`=1 leave the register values unchanged.
- Assert `i_rst_b` mid-copy → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/gfx_dma_pkg.sv
// Shared definitions for the gfx_dma rectangular blit engine: register
// offsets, copy state encoding and the destination row stride.
package gfx_dma_pkg;

  localparam logic [2:0] REG_SRC_L  = 3'd0;
  localparam logic [2:0] REG_SRC_H  = 3'd1;
  localparam logic [2:0] REG_DST_L  = 3'd2;
  localparam logic [2:0] REG_DST_H  = 3'd3;
  localparam logic [2:0] REG_WIDTH  = 3'd4;
  localparam logic [2:0] REG_HEIGHT = 3'd5;
  localparam logic [2:0] REG_MASK   = 3'd6;
  localparam logic [2:0] REG_START  = 3'd7;

  localparam logic [15:0] DST_STRIDE = 16'd256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_NEXT  = 2'd3
  } state_e;

  function automatic logic [7:0] apply_mask(input logic [7:0] data, input logic [7:0] mask);
    return data & mask;
  endfunction

endpackage

// File: rtl/gfx_dma_if.sv
// Non-tristate control and status signals between the CPU/video side and gfx_dma.
interface gfx_dma_if;
  logic       i_src_ce_b;
  logic       i_src_ce2_b;
  logic [7:0] i_src_data;
  logic       i_free_vbus_b;
  logic       o_dst_we_b;
  logic       o_active;
  logic       o_addr_sel;

  modport master (
    output i_src_ce_b, i_src_ce2_b, i_src_data, i_free_vbus_b,
    input  o_dst_we_b, o_active, o_addr_sel
  );

  modport slave (
    input  i_src_ce_b, i_src_ce2_b, i_src_data, i_free_vbus_b,
    output o_dst_we_b, o_active, o_addr_sel
  );
endinterface

// File: rtl/gfx_dma_regs.sv
// Blit parameter registers. A CPU write is latched while the strobe is low and
// committed on the first clock the strobe is seen high again.
module gfx_dma_regs
  import gfx_dma_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_b,
  input  logic        i_sel,
  input  logic        i_we_b,
  input  logic [2:0]  i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_active,
  output logic [12:0] o_src,
  output logic [15:0] o_dst,
  output logic [7:0]  o_width,
  output logic [7:0]  o_height,
  output logic [7:0]  o_mask,
  output logic        o_start
);

  logic       pend_q, pend_d;
  logic [2:0] lat_addr_q, lat_addr_d;
  logic [7:0] lat_data_q, lat_data_d;
  logic [7:0] src_l_q, src_l_d;
  logic [4:0] src_h_q, src_h_d;
  logic [7:0] dst_l_q, dst_l_d;
  logic [7:0] dst_h_q, dst_h_d;
  logic [7:0] width_q, width_d;
  logic [7:0] height_q, height_d;
  logic [7:0] mask_q, mask_d;
  logic       start_q, start_d;

  always_comb begin
    pend_d     = pend_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    src_l_d    = src_l_q;
    src_h_d    = src_h_q;
    dst_l_d    = dst_l_q;
    dst_h_d    = dst_h_q;
    width_d    = width_q;
    height_d   = height_q;
    mask_d     = mask_q;
    start_d    = 1'b0;
    // While the copy owns the bus, any half-finished CPU write is dropped.
    if (i_active) begin
      pend_d = 1'b0;
    end else if (!i_we_b) begin
      if (i_sel) begin
        pend_d     = 1'b1;
        lat_addr_d = i_addr;
        lat_data_d = i_data;
      end else begin
        pend_d = pend_q;
      end
    end else if (pend_q) begin
      pend_d = 1'b0;
      case (lat_addr_q)
        REG_SRC_L:  src_l_d  = lat_data_q;
        REG_SRC_H:  src_h_d  = lat_data_q[4:0];
        REG_DST_L:  dst_l_d  = lat_data_q;
        REG_DST_H:  dst_h_d  = lat_data_q;
        REG_WIDTH:  width_d  = lat_data_q;
        REG_HEIGHT: height_d = lat_data_q;
        REG_MASK:   mask_d   = lat_data_q;
        REG_START:  start_d  = 1'b1;
        default:    start_d  = 1'b0;
      endcase
    end else begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      pend_q     <= 1'b0;
      lat_addr_q <= 3'd0;
      lat_data_q <= 8'd0;
      src_l_q    <= 8'd0;
      src_h_q    <= 5'd0;
      dst_l_q    <= 8'd0;
      dst_h_q    <= 8'd0;
      width_q    <= 8'd0;
      height_q   <= 8'd0;
      mask_q     <= 8'd0;
      start_q    <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      src_l_q    <= src_l_d;
      src_h_q    <= src_h_d;
      dst_l_q    <= dst_l_d;
      dst_h_q    <= dst_h_d;
      width_q    <= width_d;
      height_q   <= height_d;
      mask_q     <= mask_d;
      start_q    <= start_d;
    end
  end

  assign o_src    = {src_h_q, src_l_q};
  assign o_dst    = {dst_h_q, dst_l_q};
  assign o_width  = width_q;
  assign o_height = height_q;
  assign o_mask   = mask_q;
  assign o_start  = start_q;

endmodule

// File: rtl/gfx_dma.sv
// Rectangular blit engine: linear cram source to strided vram destination,
// 3 cycles per byte, stalling in READ while the video scan owns vram.
module gfx_dma
  import gfx_dma_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_b,
  gfx_dma_if.slave   bus,
  output wire        o_src_re_b,
  inout  wire        io_src_we_b,
  inout  wire [12:0] io_src_addr,
  output wire [15:0] o_dst_addr,
  output wire [7:0]  o_dst_data
);

  logic [12:0] reg_src_s;
  logic [15:0] reg_dst_s;
  logic [7:0]  reg_width_s, reg_height_s, reg_mask_s;
  logic        start_s, sel_s;
  logic [7:0]  col_inc_s, row_inc_s;

  state_e      state_q, state_d;
  logic [12:0] src_ptr_q, src_ptr_d;
  logic [15:0] row_base_q, row_base_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [15:0] dst_addr_q, dst_addr_d;
  logic [7:0]  dst_data_q, dst_data_d;
  logic        dst_we_b_q, dst_we_b_d;
  logic        src_re_b_q, src_re_b_d;
  logic        drv_q, drv_d;
  logic        active_q, active_d;

  assign sel_s = ~bus.i_src_ce_b & ~bus.i_src_ce2_b;

  gfx_dma_regs u_regs (
    .i_clk    (i_clk),
    .i_rst_b  (i_rst_b),
    .i_sel    (sel_s),
    .i_we_b   (io_src_we_b),
    .i_addr   (io_src_addr[2:0]),
    .i_data   (bus.i_src_data),
    .i_active (active_q),
    .o_src    (reg_src_s),
    .o_dst    (reg_dst_s),
    .o_width  (reg_width_s),
    .o_height (reg_height_s),
    .o_mask   (reg_mask_s),
    .o_start  (start_s)
  );

  assign col_inc_s = col_q + 8'd1;
  assign row_inc_s = row_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    dst_we_b_d = 1'b1;
    src_re_b_d = src_re_b_q;
    drv_d      = drv_q;
    active_d   = active_q;
    case (state_q)
      ST_IDLE: begin
        active_d   = 1'b0;
        drv_d      = 1'b0;
        src_re_b_d = 1'b1;
        if (start_s) begin
          active_d = 1'b1;
          // An empty rectangle still reports one busy cycle but touches no bus.
          if ((reg_width_s == 8'd0) || (reg_height_s == 8'd0)) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_READ;
            drv_d      = 1'b1;
            src_re_b_d = 1'b0;
            src_ptr_d  = reg_src_s;
            row_base_d = reg_dst_s;
            col_d      = 8'd0;
            row_d      = 8'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!bus.i_free_vbus_b) begin
          state_d    = ST_WRITE;
          src_re_b_d = 1'b1;
          dst_addr_d = row_base_q + {8'd0, col_q};
          dst_data_d = apply_mask(bus.i_src_data, reg_mask_s);
          dst_we_b_d = 1'b0;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        src_ptr_d = src_ptr_q + 13'd1;
        if (col_inc_s == reg_width_s) begin
          col_d      = 8'd0;
          row_d      = row_inc_s;
          row_base_d = row_base_q + DST_STRIDE;
          if (row_inc_s == reg_height_s) begin
            state_d    = ST_IDLE;
            active_d   = 1'b0;
            drv_d      = 1'b0;
            src_re_b_d = 1'b1;
          end else begin
            state_d    = ST_READ;
            src_re_b_d = 1'b0;
          end
        end else begin
          col_d      = col_inc_s;
          state_d    = ST_READ;
          src_re_b_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        active_d   = 1'b0;
        drv_d      = 1'b0;
        src_re_b_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= ST_IDLE;
      src_ptr_q  <= 13'd0;
      row_base_q <= 16'd0;
      col_q      <= 8'd0;
      row_q      <= 8'd0;
      dst_addr_q <= 16'd0;
      dst_data_q <= 8'd0;
      dst_we_b_q <= 1'b1;
      src_re_b_q <= 1'b1;
      drv_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      dst_we_b_q <= dst_we_b_d;
      src_re_b_q <= src_re_b_d;
      drv_q      <= drv_d;
      active_q   <= active_d;
    end
  end

  // drv_q is high exactly in READ/WRITE/NEXT, so it gates every shared bus.
  assign io_src_addr = drv_q ? src_ptr_q : {13{1'bz}};
  assign io_src_we_b = drv_q ? 1'b1 : 1'bz;
  assign o_src_re_b  = drv_q ? src_re_b_q : 1'bz;
  assign o_dst_addr  = drv_q ? dst_addr_q : {16{1'bz}};
  assign o_dst_data  = drv_q ? dst_data_q : {8{1'bz}};

  assign bus.o_dst_we_b = dst_we_b_q;
  assign bus.o_active   = active_q;
  assign bus.o_addr_sel = drv_q;

endmodule

// File: tb/tb_gfx_dma.sv
// Table-driven bench for gfx_dma with a cram model and a vram write scoreboard.
module tb_gfx_dma;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  w;
    logic [7:0]  h;
    logic [7:0]  mask;
    int          stall_at;
    int          cycles;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_b = 1'b0;
  logic        cpu_we_b = 1'b1;
  logic [12:0] cpu_addr = 13'd0;
  logic [7:0]  cpu_data = 8'd0;
  logic [7:0]  cram [0:8191];
  logic [23:0] sb [$];
  logic [23:0] exp_w;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs [7];

  wire         o_src_re_b;
  wire         io_src_we_b;
  wire  [12:0] io_src_addr;
  wire  [15:0] o_dst_addr;
  wire  [7:0]  o_dst_data;

  gfx_dma_if bus ();

  gfx_dma dut (
    .i_clk       (i_clk),
    .i_rst_b     (i_rst_b),
    .bus         (bus),
    .o_src_re_b  (o_src_re_b),
    .io_src_we_b (io_src_we_b),
    .io_src_addr (io_src_addr),
    .o_dst_addr  (o_dst_addr),
    .o_dst_data  (o_dst_data)
  );

  always #5 i_clk = ~i_clk;

  // o_active disables the CPU bus buffers, as on the board.
  assign io_src_we_b    = bus.o_active ? 1'bz : cpu_we_b;
  assign io_src_addr    = bus.o_active ? {13{1'bz}} : cpu_addr;
  assign bus.i_src_data = bus.o_active ? cram[io_src_addr] : cpu_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_b && (bus.o_dst_we_b == 1'b0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%h data 0x%h expected no write", o_dst_addr, o_dst_data);
      end else begin
        exp_w = sb.pop_front();
        check("vram_write", {8'd0, o_dst_addr, o_dst_data}, {8'd0, exp_w});
      end
    end
  end

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge i_clk);
    cpu_addr = {10'd0, a};
    cpu_data = d;
    bus.i_src_ce_b = 1'b0;
    bus.i_src_ce2_b = 1'b0;
    cpu_we_b = 1'b0;
    @(negedge i_clk);
    cpu_we_b = 1'b1;
    @(negedge i_clk);
    bus.i_src_ce_b = 1'b1;
    bus.i_src_ce2_b = 1'b1;
  endtask

  task automatic program_regs(input vec_t v);
    cpu_write(3'd0, v.src[7:0]);
    cpu_write(3'd1, v.src[15:8]);
    cpu_write(3'd2, v.dst[7:0]);
    cpu_write(3'd3, v.dst[15:8]);
    cpu_write(3'd4, v.w);
    cpu_write(3'd5, v.h);
    cpu_write(3'd6, v.mask);
  endtask

  task automatic push_expected(input vec_t v);
    logic [15:0] a;
    logic [12:0] s;
    for (int r = 0; r < int'(v.h); r++) begin
      for (int c = 0; c < int'(v.w); c++) begin
        a = v.dst + 16'(r * 256 + c);
        s = v.src[12:0] + 13'(r * int'(v.w) + c);
        sb.push_back({a, cram[s] & v.mask});
      end
    end
  endtask

  // Counts o_active cycles of one copy; optionally stalls the video bus
  // for two cycles starting in the READ cycle numbered stall_at.
  task automatic measure(input int stall_at, input int exp_cycles, input string nm);
    int  n = 0;
    int  first = -1;
    bit  done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge i_clk);
      if (bus.o_active) begin
        if (first < 0) first = k;
        n++;
        if ((stall_at != 0) && (n == stall_at)) begin
          bus.i_free_vbus_b = 1'b1;
          repeat (2) begin
            @(negedge i_clk);
            n++;
            check({nm, "_stall_we"}, {31'd0, bus.o_dst_we_b}, 32'd1);
          end
          bus.i_free_vbus_b = 1'b0;
        end
      end else if (n > 0) begin
        done = 1'b1;
      end
    end
    check({nm, "_start_latency"}, first, 32'd0);
    check({nm, "_active_cycles"}, n, exp_cycles);
    check({nm, "_writes_left"}, sb.size(), 32'd0);
    check({nm, "_addr_sel_end"}, {31'd0, bus.o_addr_sel}, 32'd0);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) cram[i] = 8'(i ^ (i >> 5) ^ 8'h3C);
    cram[13'h0100] = 8'hA5;

    vecs[0] = '{16'h0000, 16'h1010, 8'd5, 8'd5, 8'hFF, 0, 75};
    vecs[1] = '{16'h0100, 16'h2000, 8'd1, 8'd1, 8'h0F, 0, 3};
    vecs[2] = '{16'h0000, 16'h1010, 8'd5, 8'd5, 8'hFF, 7, 77};
    vecs[3] = '{16'h0040, 16'h3000, 8'd0, 8'd3, 8'hFF, 0, 1};
    vecs[4] = '{16'h0040, 16'h3000, 8'd3, 8'd0, 8'hFF, 0, 1};
    vecs[5] = '{16'hFFFE, 16'hFEFE, 8'd4, 8'd2, 8'hF0, 0, 24};
    vecs[6] = '{16'h0123, 16'h0000, 8'd3, 8'd4, 8'h3C, 4, 38};

    bus.i_src_ce_b = 1'b1;
    bus.i_src_ce2_b = 1'b1;
    bus.i_free_vbus_b = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_active", {31'd0, bus.o_active}, 32'd0);
    check("reset_addr_sel", {31'd0, bus.o_addr_sel}, 32'd0);
    check("reset_dst_we_b", {31'd0, bus.o_dst_we_b}, 32'd1);
    i_rst_b = 1'b1;

    for (int v = 0; v < 7; v++) begin
      push_expected(vecs[v]);
      program_regs(vecs[v]);
      cpu_write(3'd7, 8'h00);
      measure(vecs[v].stall_at, vecs[v].cycles, $sformatf("vec%0d", v));
    end

    // Register writes attempted during a copy must not alter the next START.
    push_expected(vecs[0]);
    program_regs(vecs[0]);
    cpu_write(3'd7, 8'h00);
    fork
      measure(0, 75, "busy");
      begin
        repeat (6) @(negedge i_clk);
        cpu_write(3'd4, 8'd2);
        cpu_write(3'd6, 8'h00);
      end
    join
    push_expected(vecs[0]);
    cpu_write(3'd7, 8'h00);
    measure(0, 75, "restart");

    // Asynchronous reset in the middle of a copy.
    push_expected(vecs[0]);
    cpu_write(3'd7, 8'h00);
    repeat (10) @(negedge i_clk);
    #2 i_rst_b = 1'b0;
    #1;
    check("midrst_active", {31'd0, bus.o_active}, 32'd0);
    check("midrst_addr_sel", {31'd0, bus.o_addr_sel}, 32'd0);
    check("midrst_dst_we_b", {31'd0, bus.o_dst_we_b}, 32'd1);
    sb.delete();
    @(negedge i_clk);
    i_rst_b = 1'b1;
    cpu_write(3'd7, 8'h00);
    measure(0, 1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
